// File: rtl/issuer_pkg.sv
// Shared constants, FSM state encoding and the R-type packing helper for the
// instruction issue unit.
package issuer_pkg;

  localparam logic [5:0]  OP_RTYPE  = 6'h00;
  localparam logic [5:0]  FUNCT_ADD = 6'h20;
  localparam logic [5:0]  FUNCT_SUB = 6'h22;
  localparam logic [5:0]  FUNCT_AND = 6'h24;
  localparam logic [5:0]  FUNCT_OR  = 6'h25;
  localparam logic [5:0]  FUNCT_SLT = 6'h2A;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } issue_state_e;

  function automatic logic [31:0] pack_rtype(
    input logic [5:0] opcode,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [4:0] shamt,
    input logic [5:0] funct
  );
    return {opcode, rs, rt, rd, shamt, funct};
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed instruction words.
// dout always shows the head entry; it is meaningless while empty is high.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/instr_issue_unit.sv
// Packs R-type fields into MIPS words, queues them and issues one per cycle to the
// datapath, capturing each result with its rd. Optional opcode check: ISSUER_OPCHK_EN.
module instr_issue_unit
  import issuer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_opcode,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [5:0]       in_funct,
  input  logic             stall,
  output logic [31:0]      instruction,
  output logic             instr_valid,
  input  logic [31:0]      result,
  output logic             res_valid,
  output logic [31:0]      res_data,
  output logic [4:0]       res_rd,
  output logic [CNT_W-1:0] issued_count,
  output logic             err_pulse,
  output logic [1:0]       debug_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  issue_state_e state_q;
  issue_state_e state_d;
  logic [31:0]  packed_word;
  logic [31:0]  fifo_dout;
  logic         fifo_full;
  logic         fifo_empty;
  logic         accept;
  logic         op_ok;
  logic         push;
  logic         pop;

  // Handshake: a field set transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on FIFO occupancy, so a full FIFO refuses even when popping.
  assign in_ready    = !fifo_full;
  assign accept      = in_valid && !fifo_full;
  assign push        = accept && op_ok;
  assign packed_word = pack_rtype(in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct);
  assign debug_state = state_q;

  issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (packed_word),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE, STALL: begin
        if (!stall) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      ISSUE: begin
        // The word already on instruction completes; stall only blocks the next pop.
        if (stall)
          state_d = STALL;
        else if (!fifo_empty)
          pop = 1'b1;
        else
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      instruction  <= NOP_INSTR;
      instr_valid  <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_rd       <= '0;
      issued_count <= '0;
    end else begin
      state_q     <= state_d;
      instruction <= pop ? fifo_dout : NOP_INSTR;
      instr_valid <= pop;
      res_valid   <= instr_valid;
      if (instr_valid) begin
        res_data <= result;
        res_rd   <= instruction[15:11];
      end
      if (pop)
        issued_count <= issued_count + CNT_ONE;
    end
  end

`ifdef ISSUER_OPCHK_EN
  assign op_ok = (in_opcode == OP_RTYPE);

  always_ff @(posedge clk) begin
    if (reset)
      err_pulse <= 1'b0;
    else
      err_pulse <= accept && !op_ok;
  end
`else
  assign op_ok     = 1'b1;
  assign err_pulse = 1'b0;
`endif

endmodule
